dmem_sized: RTL and testbench

DMEM_SIZED -- requirements
Module: dmem_sized

---
 rtl/dmem_sized.sv | 163 ++++++++++++++++
 tb/tb_dmem_sized.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_sized.sv
// Byte/half/word data memory with RISC-V load/store sizing and a fixed-latency IDLE/BUSY handshake.
// Optional build macro DMEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into faults.
//
// state | meaning
// IDLE  | ready high, waiting for req
// BUSY  | request captured, down-counter runs LATENCY cycles, op executes on the last edge
module dmem_sized #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] a,
  input  logic [31:0]       wd,
  output logic              ready,
  output logic              rvalid,
  output logic [31:0]       rd,
  output logic              fault
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [1:0] LAT_M1 = 2'(LATENCY - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [1:0]       cnt;
  logic             we_q;
  logic [2:0]       f3_q;
  logic [IDX_W+1:0] a_q;
  logic [31:0]      wd_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic             legal;
  logic             size_h;
  logic             size_w;
  logic             misalign;
  logic             bad;
  logic [1:0]       lane;
  logic [IDX_W-1:0] idx;
  logic [3:0]       be;
  logic [31:0]      wdata;
  logic [31:0]      word;
  logic [31:0]      sh_word;
  logic [31:0]      ld_data;
  logic             done;
  logic             mem_we;

  // Address bits above the wrapped word index are intentionally ignored.
  generate
    if (ADDR_W > IDX_W + 2) begin : g_unused_hi
      logic unused_a_hi;
      assign unused_a_hi = ^a[ADDR_W-1:IDX_W+2];
    end
  endgenerate

  always_comb begin
    legal = 1'b0;
    case (f3_q)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !we_q;
      default:                legal = 1'b0;
    endcase
    size_h   = (f3_q[1:0] == 2'b01);
    size_w   = (f3_q[1:0] == 2'b10);
    misalign = (size_h & a_q[0]) | (size_w & (a_q[1:0] != 2'b00));
`ifdef DMEM_MISALIGN_TRAP_EN
    bad = !legal || misalign;
`else
    bad = !legal;
`endif
    // Without trapping, misaligned halves/words are aligned down here.
    if (size_w)      lane = 2'b00;
    else if (size_h) lane = {a_q[1], 1'b0};
    else             lane = a_q[1:0];
    idx = a_q[IDX_W+1:2];

    if (size_w) begin
      be    = 4'b1111;
      wdata = wd_q;
    end else if (size_h) begin
      be    = 4'b0011 << lane;
      wdata = {2{wd_q[15:0]}};
    end else begin
      be    = 4'b0001 << lane;
      wdata = {4{wd_q[7:0]}};
    end

    word    = mem[idx];
    sh_word = word >> {lane, 3'b000};
    case (f3_q)
      3'b000:  ld_data = {{24{sh_word[7]}}, sh_word[7:0]};
      3'b001:  ld_data = {{16{sh_word[15]}}, sh_word[15:0]};
      3'b010:  ld_data = word;
      3'b100:  ld_data = {24'b0, sh_word[7:0]};
      3'b101:  ld_data = {16'b0, sh_word[15:0]};
      default: ld_data = 32'b0;
    endcase

    done   = (state == BUSY) && (cnt == 2'd0);
    mem_we = done && we_q && !bad && !reset;
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 2'd0;
      ready  <= 1'b1;
      rvalid <= 1'b0;
      fault  <= 1'b0;
      rd     <= 32'b0;
      we_q   <= 1'b0;
      f3_q   <= 3'b0;
      a_q    <= '0;
      wd_q   <= 32'b0;
    end else begin
      rvalid <= 1'b0;
      fault  <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            we_q  <= we;
            f3_q  <= funct3;
            a_q   <= a[IDX_W+1:0];
            wd_q  <= wd;
            cnt   <= LAT_M1;
            ready <= 1'b0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == 2'd0) begin
            state <= IDLE;
            ready <= 1'b1;
            fault <= bad;
            if (!we_q) begin
              rvalid <= 1'b1;
              rd     <= bad ? 32'b0 : ld_data;
            end
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_sized.sv
// Randomized scoreboard bench for dmem_sized: a byte-array model predicts each completion,
// a negedge monitor checks outputs, completion timing and busy length.
module tb_dmem_sized;
  localparam int LAT   = 3;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [31:0] a = 32'b0;
  logic [31:0] wd = 32'b0;
  logic        ready;
  logic        rvalid;
  logic        fault;
  logic [31:0] rd;

  dmem_sized #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .funct3(funct3), .a(a), .wd(wd),
    .ready(ready), .rvalid(rvalid), .rd(rd), .fault(fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    bit          rv;
    bit          flt;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  byte unsigned mem_m [4*DEPTH];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          run = 0;
  bit          abort_run = 1'b0;
  bit          mon_en = 1'b0;
  logic [31:0] last_rd = 32'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: byte-addressed memory, size from funct3, address wraps modulo 4*DEPTH.
  task automatic model(input bit w, input logic [2:0] f3, input logic [31:0] ad,
                       input logic [31:0] d, output bit out, output bit flt,
                       output logic [31:0] v);
    int  sz;
    int  base;
    bit  legal;
    bit  mis;
    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
            (!w && (f3 == 3'd4 || f3 == 3'd5));
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    mis = (ad % sz) != 0;
    flt = !legal;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (legal && mis) flt = 1'b1;
`endif
    base = int'(((ad - (ad % sz)) % (4*DEPTH)));
    out = !w;
    v = 32'b0;
    if (!flt) begin
      if (w) begin
        for (int i = 0; i < sz; i++) mem_m[base+i] = d[8*i +: 8];
      end else begin
        for (int i = 0; i < sz; i++) v = v | (32'(mem_m[base+i]) << (8*i));
        if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
      end
    end
  endtask

  // Called at posedge+1; returns one cycle after the request was presented.
  task automatic issue(input bit w, input logic [2:0] f3, input logic [31:0] ad,
                       input logic [31:0] d, input bit hold = 1'b0);
    int          k;
    bit          o;
    bit          f;
    logic [31:0] v;
    exp_t        e;
    for (int t = 0; !ready; t++) begin
      if (t > 20) begin
        n_cmp++;
        n_bad++;
        $display("FAIL ready_timeout: ready still %0b after %0d cycles", ready, t);
        return;
      end
      @(posedge clk); #1;
    end
    req = 1'b1; we = w; funct3 = f3; a = ad; wd = d;
    k = cyc;
    model(w, f3, ad, d, o, f, v);
    if (o || f) begin
      e.cyc  = k + 1 + LAT;
      e.rv   = o;
      e.flt  = f;
      e.data = f ? 32'b0 : v;
      q.push_back(e);
    end
    @(posedge clk); #1;
    if (hold) begin
      we = 1'b0; funct3 = 3'b010; a = $urandom;
      repeat (LAT) begin @(posedge clk); #1; end
    end
    req = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (reset) begin
        last_rd   = 32'b0;
        abort_run = 1'b1;
      end else begin
        if (ready) begin
          if (run > 0 && !abort_run) chk("ready_low_cycles", 32'(run), 32'(LAT));
          run = 0;
          abort_run = 1'b0;
        end else begin
          run++;
        end
        if (rvalid || fault) begin
          if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_output: rvalid=%0b fault=%0b rd=%08h, none expected", rvalid, fault, rd);
          end else begin
            mon_e = q.pop_front();
            chk("completion_cycle", 32'(cyc), 32'(mon_e.cyc));
            chk("rvalid", {31'b0, rvalid}, {31'b0, mon_e.rv});
            chk("fault", {31'b0, fault}, {31'b0, mon_e.flt});
            if (mon_e.rv) begin
              chk("rd", rd, mon_e.data);
              last_rd = mon_e.data;
            end
          end
        end else if (q.size() > 0 && q[0].cyc < cyc) begin
          n_cmp++;
          n_bad++;
          $display("FAIL missing_output: nothing seen, expected at cycle %0d", q[0].cyc);
          void'(q.pop_front());
        end
        if (!rvalid) chk("rd_hold", rd, last_rd);
      end
    end
  end

  initial begin
    bit          w;
    logic [2:0]  f3;
    logic [31:0] ad;
    int          k;
    logic [2:0]  legal_f3 [5];
    legal_f3[0] = 3'd0; legal_f3[1] = 3'd1; legal_f3[2] = 3'd2;
    legal_f3[3] = 3'd4; legal_f3[4] = 3'd5;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {31'b0, ready}, 32'd1);
    chk("reset_rvalid", {31'b0, rvalid}, 32'd0);
    chk("reset_fault", {31'b0, fault}, 32'd0);
    chk("reset_rd", rd, 32'd0);
    reset = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < DEPTH; i++) issue(1'b1, 3'b010, 32'(i*4), $urandom);

    issue(1'b1, 3'b010, 32'h0, 32'hDEAD_BEEF);
    issue(1'b0, 3'b010, 32'h100, 32'h0);
    issue(1'b1, 3'b010, 32'h4, 32'hCAFE_BABE);
    issue(1'b1, 3'b000, 32'h5, 32'h0000_0080);
    issue(1'b0, 3'b010, 32'h4, 32'h0);
    issue(1'b0, 3'b000, 32'h5, 32'h0);
    issue(1'b0, 3'b100, 32'h5, 32'h0);
    issue(1'b1, 3'b001, 32'h6, 32'h0000_8234);
    issue(1'b0, 3'b001, 32'h6, 32'h0);
    issue(1'b0, 3'b101, 32'h6, 32'h0);
    issue(1'b0, 3'b010, 32'h4, 32'h0);
    issue(1'b0, 3'b010, 32'h6, 32'h0);
    issue(1'b1, 3'b011, 32'h0, 32'h1111_1111);
    issue(1'b0, 3'b010, 32'h0, 32'h0);
    issue(1'b1, 3'b100, 32'h3, 32'h0000_00AA);
    issue(1'b0, 3'b111, 32'h8, 32'h0);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
    issue(1'b0, 3'b010, 32'h3, 32'h0);

    // Store aborted by reset in its second busy cycle must leave memory untouched.
    for (int t = 0; !ready && t < 20; t++) begin @(posedge clk); #1; end
    req = 1'b1; we = 1'b1; funct3 = 3'b010; a = 32'h8; wd = 32'h55AA_55AA;
    k = cyc;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_ready", {31'b0, ready}, 32'd1);
    chk("abort_rvalid", {31'b0, rvalid}, 32'd0);
    chk("abort_fault", {31'b0, fault}, 32'd0);
    chk("abort_rd", rd, 32'd0);
    chk("abort_cycle", 32'(cyc - k), 32'd3);
    reset = 1'b0;
    issue(1'b0, 3'b010, 32'h8, 32'h0);

    repeat (400) begin
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) f3 = legal_f3[$urandom_range(0, 4)];
      else f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) != 0) ad = $urandom;
      else ad = 32'($urandom_range(0, 4*DEPTH - 1));
      issue(w, f3, ad, $urandom, ($urandom_range(0, 15) == 0));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (LAT + 4) @(posedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
